// File: rtl/sky130_sram_1rw1r_ctrl.sv
// Controller for the sky130 32x512 1RW+1R SRAM macro: two valid/ready request channels
// become registered macro pin activity, read data returns on response channels.
module sky130_sram_1rw1r_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [NUM_WMASKS-1:0] a_req_wmask,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  input  logic                  a_rsp_ready,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  output logic                  b_rsp_valid,
  input  logic                  b_rsp_ready,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
);

  // Handshake: a transfer happens on a posedge where valid & ready are both high;
  // valid must hold its payload stable until that edge, ready may depend on valid.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACC = 2'd1, ST_RSP = 2'd2} state_e;

  state_e                a_state_q, a_state_d, b_state_q, b_state_d;
  logic                  csb0_q, csb0_d, web0_q, web0_d, csb1_q, csb1_d;
  logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic                  a_rsp_valid_q, a_rsp_valid_d, b_rsp_valid_q, b_rsp_valid_d;
  logic [DATA_WIDTH-1:0] a_rsp_rdata_q, a_rsp_rdata_d, b_rsp_rdata_q, b_rsp_rdata_d;
  logic                  a_acc, b_acc, b_hazard;

  assign a_acc    = a_req_valid & a_req_ready;
  // A write accepted this edge to B's address would race B's read; hold B one cycle.
  assign b_hazard = a_acc & a_req_we & (a_req_addr == b_req_addr);
  assign b_acc    = b_req_valid & b_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_state_q     <= ST_IDLE;
      b_state_q     <= ST_IDLE;
      csb0_q        <= 1'b1;
      web0_q        <= 1'b1;
      wmask0_q      <= '0;
      addr0_q       <= '0;
      din0_q        <= '0;
      csb1_q        <= 1'b1;
      addr1_q       <= '0;
      a_rsp_valid_q <= 1'b0;
      a_rsp_rdata_q <= '0;
      b_rsp_valid_q <= 1'b0;
      b_rsp_rdata_q <= '0;
    end else begin
      a_state_q     <= a_state_d;
      b_state_q     <= b_state_d;
      csb0_q        <= csb0_d;
      web0_q        <= web0_d;
      wmask0_q      <= wmask0_d;
      addr0_q       <= addr0_d;
      din0_q        <= din0_d;
      csb1_q        <= csb1_d;
      addr1_q       <= addr1_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      a_rsp_rdata_q <= a_rsp_rdata_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      b_rsp_rdata_q <= b_rsp_rdata_d;
    end
  end

  always_comb begin
    a_state_d = a_state_q;
    case (a_state_q)
      ST_IDLE: if (a_acc) a_state_d = ST_ACC;
      ST_ACC:  a_state_d = web0_q ? ST_RSP : ST_IDLE;
      ST_RSP:  if (a_rsp_ready) a_state_d = ST_IDLE;
      default: a_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    b_state_d = b_state_q;
    case (b_state_q)
      ST_IDLE: if (b_acc) b_state_d = ST_ACC;
      ST_ACC:  b_state_d = ST_RSP;
      ST_RSP:  if (b_rsp_ready) b_state_d = ST_IDLE;
      default: b_state_d = ST_IDLE;
    endcase
  end

  // In ACC web0_q still holds ~we, so it tells a read from a write.
  always_comb begin
    a_req_ready   = (a_state_q == ST_IDLE);
    csb0_d        = csb0_q;
    web0_d        = web0_q;
    wmask0_d      = wmask0_q;
    addr0_d       = addr0_q;
    din0_d        = din0_q;
    a_rsp_valid_d = a_rsp_valid_q;
    a_rsp_rdata_d = a_rsp_rdata_q;
    case (a_state_q)
      ST_IDLE: if (a_acc) begin
        csb0_d   = 1'b0;
        web0_d   = ~a_req_we;
        wmask0_d = a_req_we ? a_req_wmask : '0;
        addr0_d  = a_req_addr;
        din0_d   = a_req_wdata;
      end
      ST_ACC: begin
        csb0_d = 1'b1;
        web0_d = 1'b1;
        if (web0_q) begin
          a_rsp_valid_d = 1'b1;
          a_rsp_rdata_d = dout0;
        end
      end
      ST_RSP: if (a_rsp_ready) a_rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    b_req_ready   = (b_state_q == ST_IDLE) & ~b_hazard;
    csb1_d        = csb1_q;
    addr1_d       = addr1_q;
    b_rsp_valid_d = b_rsp_valid_q;
    b_rsp_rdata_d = b_rsp_rdata_q;
    case (b_state_q)
      ST_IDLE: if (b_acc) begin
        csb1_d  = 1'b0;
        addr1_d = b_req_addr;
      end
      ST_ACC: begin
        csb1_d        = 1'b1;
        b_rsp_valid_d = 1'b1;
        b_rsp_rdata_d = dout1;
      end
      ST_RSP: if (b_rsp_ready) b_rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign csb0        = csb0_q;
  assign web0        = web0_q;
  assign wmask0      = wmask0_q;
  assign addr0       = addr0_q;
  assign din0        = din0_q;
  assign csb1        = csb1_q;
  assign addr1       = addr1_q;
  assign a_rsp_valid = a_rsp_valid_q;
  assign a_rsp_rdata = a_rsp_rdata_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign b_rsp_rdata = b_rsp_rdata_q;

endmodule
